parser_head_gen: RTL and testbench

- Front-end stage that feeds the first Parser_Layer of the parser pipeline.
- Accepts a narrow packet word stream (valid/ready/last) and gathers consecutive words into HEAD_WIDTH-bit head slices.
- Emits each slice as a layer_info_t beat, with tag bits set and initial lookup offsets loaded for layer 0.
- Words past MAX_SLICES slices are consumed and discarded; the parser only sees the header region.

---
 rtl/parser_head_gen_if.sv | 64 ++++++
 rtl/parser_head_gen.sv | 189 ++++++++++++++++++
 tb/tb_parser_head_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/parser_head_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : parser_head_gen_pkg / parser_head_gen_if
// Description : Shared layer_info_t beat definition for the parser pipeline
//               and the packet word stream interface (valid/ready/last)
//               that feeds parser_head_gen.
//               Interface signals:
//                 pkt_valid  word valid          (master -> slave)
//                 pkt_data   word, first byte MSB (master -> slave)
//                 pkt_last   last word of packet (master -> slave)
//                 pkt_ready  slave can accept    (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
package parser_head_gen_pkg;

  localparam int HEAD_WIDTH        = 512;
  localparam int TYPE_NUM          = 4;
  localparam int TYPE_OFFSET_WIDTH = 8;
  localparam int KEY_FILED_NUM     = 4;
  localparam int KEY_OFFSET_WIDTH  = 8;
  localparam int HEAD_SHIFT_WIDTH  = 8;
  localparam int META_WIDTH        = 32;
  localparam int META_SHIFT_WIDTH  = 8;

  typedef struct packed {
    logic                                      tag_valid;
    logic                                      tag_start;
    logic                                      tag_last;
    logic [HEAD_WIDTH-1:0]                     head;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     type_offset;
    logic [KEY_FILED_NUM-1:0]                  key_offset_v;
    logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] key_offset;
    logic [HEAD_SHIFT_WIDTH-1:0]               headShift;
    logic [META_WIDTH-1:0]                     meta;
    logic [META_SHIFT_WIDTH-1:0]               metaShift;
  } layer_info_t;

endpackage

interface parser_head_gen_if #(
  parameter int PKT_WIDTH = 128
) ();

  logic                 pkt_valid;
  logic [PKT_WIDTH-1:0] pkt_data;
  logic                 pkt_last;
  logic                 pkt_ready;

  modport master (
    output pkt_valid,
    output pkt_data,
    output pkt_last,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_data,
    input  pkt_last,
    output pkt_ready
  );

endinterface
`default_nettype wire

// File: rtl/parser_head_gen.sv
`default_nettype none
// ============================================================================
// Module      : parser_head_gen
// Description : Front end of the parser pipeline. Gathers consecutive packet
//               words into HEAD_WIDTH-bit head slices and emits each slice as
//               a layer_info_t beat for Parser_Layer 0, with tags set and the
//               layer-0 lookup offsets attached. Only the first MAX_SLICES
//               slices of a packet are forwarded; later words are dropped.
// Ports       : i_clk               clock
//               i_rst_n             asynchronous active-low reset
//               pkt_if              word stream (slave modport)
//               i_init_type_offset  layer-0 type offsets (index 0 in MSBs)
//               i_init_key_offset_v layer-0 key-offset valid bits
//               i_init_key_offset   layer-0 key offsets
//               i_init_head_shift   layer-0 head shift
//               o_layer_info        slice beat, valid for one cycle
//               o_pkt_cnt           packets completed
//               o_drop_word_cnt     words discarded after the header region
// Revision    : 1.0 - initial release
// ============================================================================
module parser_head_gen
  import parser_head_gen_pkg::*;
#(
  parameter int PKT_WIDTH  = 128,
  parameter int MAX_SLICES = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  wire                                      i_clk,
  input  wire                                      i_rst_n,
  parser_head_gen_if.slave                         pkt_if,
  input  wire [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     i_init_type_offset,
  input  wire [KEY_FILED_NUM-1:0]                  i_init_key_offset_v,
  input  wire [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] i_init_key_offset,
  input  wire [HEAD_SHIFT_WIDTH-1:0]               i_init_head_shift,
  output layer_info_t                              o_layer_info,
  output logic [CNT_WIDTH-1:0]                     o_pkt_cnt,
  output logic [CNT_WIDTH-1:0]                     o_drop_word_cnt
);

  localparam int WORDS_PER_SLICE = HEAD_WIDTH / PKT_WIDTH;
  localparam int WCNT_W = (WORDS_PER_SLICE > 1) ? $clog2(WORDS_PER_SLICE) : 1;
  localparam int SCNT_W = (MAX_SLICES > 1) ? $clog2(MAX_SLICES) : 1;
  localparam logic [WCNT_W-1:0] C_LAST_WORD  = WCNT_W'(WORDS_PER_SLICE - 1);
  localparam logic [SCNT_W-1:0] C_LAST_SLICE = SCNT_W'(MAX_SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

  state_t                                r_state;
  state_t                                w_nxt_state;
  logic [WCNT_W-1:0]                     r_wcnt,  w_nxt_wcnt;
  logic [SCNT_W-1:0]                     r_scnt,  w_nxt_scnt;
  logic [HEAD_WIDTH-1:0]                 r_head,  w_nxt_head;
  logic                                  r_ready;
  layer_info_t                           r_layer_info;
  layer_info_t                           w_beat;
  logic [CNT_WIDTH-1:0]                  r_pkt_cnt;
  logic [CNT_WIDTH-1:0]                  r_drop_cnt;

  // Packet context, captured with the first word of each packet
  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     r_ctx_type_offset;
  logic [KEY_FILED_NUM-1:0]                  r_ctx_key_offset_v;
  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] r_ctx_key_offset;
  logic [HEAD_SHIFT_WIDTH-1:0]               r_ctx_head_shift;

  logic                  w_accept;
  logic                  w_first;
  logic                  w_complete;
  logic [WCNT_W-1:0]     w_idx;
  logic [SCNT_W-1:0]     w_sidx;
  logic [HEAD_WIDTH-1:0] w_word_ext;
  logic [HEAD_WIDTH-1:0] w_slice;

  assign w_accept  = pkt_if.pkt_valid && r_ready;
  assign pkt_if.pkt_ready = r_ready;

  // The first word of a packet is handled as slot 0 of slice 0 with an empty
  // buffer, so IDLE and GATHER share one gather/complete path.
  assign w_first    = (r_state == ST_IDLE);
  assign w_idx      = w_first ? '0 : r_wcnt;
  assign w_sidx     = w_first ? '0 : r_scnt;
  assign w_word_ext = HEAD_WIDTH'(pkt_if.pkt_data)
                      << (32'(C_LAST_WORD - w_idx) * PKT_WIDTH);
  assign w_slice    = (w_first ? '0 : r_head) | w_word_ext;
  assign w_complete = pkt_if.pkt_last || (w_idx == C_LAST_WORD);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_wcnt  = r_wcnt;
    w_nxt_scnt  = r_scnt;
    w_nxt_head  = r_head;
    w_beat      = '0;

    case (r_state)
      ST_IDLE, ST_GATHER: begin
        if (w_accept) begin
          if (w_complete) begin
            w_beat.tag_valid = 1'b1;
            w_beat.tag_start = (w_sidx == '0);
            w_beat.tag_last  = pkt_if.pkt_last || (w_sidx == C_LAST_SLICE);
            w_beat.head      = w_slice;
            // On the first word the context registers load this same cycle,
            // so the beat takes the live inputs instead.
            w_beat.type_offset  = w_first ? i_init_type_offset  : r_ctx_type_offset;
            w_beat.key_offset_v = w_first ? i_init_key_offset_v : r_ctx_key_offset_v;
            w_beat.key_offset   = w_first ? i_init_key_offset   : r_ctx_key_offset;
            w_beat.headShift    = w_first ? i_init_head_shift   : r_ctx_head_shift;
            w_nxt_head = '0;
            w_nxt_wcnt = '0;
            if (pkt_if.pkt_last) begin
              w_nxt_state = ST_IDLE;
              w_nxt_scnt  = '0;
            end else if (w_sidx == C_LAST_SLICE) begin
              w_nxt_state = ST_DROP;
              w_nxt_scnt  = '0;
            end else begin
              w_nxt_state = ST_GATHER;
              w_nxt_scnt  = w_sidx + SCNT_W'(1);
            end
          end else begin
            w_nxt_state = ST_GATHER;
            w_nxt_head  = w_slice;
            w_nxt_wcnt  = w_idx + WCNT_W'(1);
            w_nxt_scnt  = w_sidx;
          end
        end
      end
      ST_DROP: begin
        if (w_accept && pkt_if.pkt_last) begin
          w_nxt_state = ST_IDLE;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wcnt             <= '0;
      r_scnt             <= '0;
      r_head             <= '0;
      r_ready            <= 1'b0;
      r_layer_info       <= '0;
      r_pkt_cnt          <= '0;
      r_drop_cnt         <= '0;
      r_ctx_type_offset  <= '0;
      r_ctx_key_offset_v <= '0;
      r_ctx_key_offset   <= '0;
      r_ctx_head_shift   <= '0;
    end else begin
      r_ready      <= 1'b1;
      r_wcnt       <= w_nxt_wcnt;
      r_scnt       <= w_nxt_scnt;
      r_head       <= w_nxt_head;
      r_layer_info <= w_beat;
      if (w_accept && w_first) begin
        r_ctx_type_offset  <= i_init_type_offset;
        r_ctx_key_offset_v <= i_init_key_offset_v;
        r_ctx_key_offset   <= i_init_key_offset;
        r_ctx_head_shift   <= i_init_head_shift;
      end
      if (w_accept && pkt_if.pkt_last) begin
        r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
      end
      if (w_accept && (r_state == ST_DROP)) begin
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign o_layer_info    = r_layer_info;
  assign o_pkt_cnt       = r_pkt_cnt;
  assign o_drop_word_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_parser_head_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_parser_head_gen
// Description : Self-checking bench for parser_head_gen. Stimulus pushes the
//               expected beats (content and arrival cycle) into a scoreboard
//               queue; a monitor pops and compares on every emitted beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parser_head_gen;
  import parser_head_gen_pkg::*;

  localparam int PW   = 128;
  localparam int WPS  = HEAD_WIDTH / PW;
  localparam int MAXS = 2;
  localparam int CW   = 32;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;

  parser_head_gen_if #(.PKT_WIDTH(PW)) bus ();

  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     init_to;
  logic [KEY_FILED_NUM-1:0]                  init_kv;
  logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] init_ko;
  logic [HEAD_SHIFT_WIDTH-1:0]               init_hs;
  layer_info_t                               li;
  logic [CW-1:0]                             pkt_cnt;
  logic [CW-1:0]                             drop_cnt;

  parser_head_gen #(
    .PKT_WIDTH  (PW),
    .MAX_SLICES (MAXS),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .pkt_if              (bus),
    .i_init_type_offset  (init_to),
    .i_init_key_offset_v (init_kv),
    .i_init_key_offset   (init_ko),
    .i_init_head_shift   (init_hs),
    .o_layer_info        (li),
    .o_pkt_cnt           (pkt_cnt),
    .o_drop_word_cnt     (drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    layer_info_t li;
    int          cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            ncyc    = 0;
  int            acc_cyc = 0;
  logic [CW-1:0] m_pkt   = '0;
  logic [CW-1:0] m_drop  = '0;

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts negedges and checks every beat against the scoreboard
  always @(negedge i_clk) begin
    exp_t e;
    ncyc++;
    if (li.tag_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat at cycle %0d expected none", ncyc);
      end else begin
        e = sb.pop_front();
        check("beat", li, e.li);
        check("beat_cycle", ncyc, e.cyc);
      end
    end else if (li !== '0) begin
      check("idle_zero", li, '0);
    end
  end

  task automatic drive_init_random();
    init_to = $urandom;
    init_kv = 4'($urandom);
    init_ko = $urandom;
    init_hs = 8'($urandom);
  endtask

  task automatic put_word(input logic [PW-1:0] d, input logic last, output bit ok);
    int b;
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = d;
    bus.pkt_last  = last;
    drive_init_random();
    ok = 1'b1;
    b  = 0;
    @(negedge i_clk);
    while (bus.pkt_ready !== 1'b1) begin
      b++;
      if (b > 20) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: got ready=%0b expected 1", bus.pkt_ready);
        ok = 1'b0;
        break;
      end
      @(negedge i_clk);
    end
    @(posedge i_clk);
    acc_cyc = ncyc;
    #1;
    bus.pkt_valid = 1'b0;
    bus.pkt_last  = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    m_pkt   = '0;
    m_drop  = '0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", bus.pkt_ready, 0);
    check("rst_layer_info", li, '0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_before_edge", bus.pkt_ready, 0);
    @(negedge i_clk);
    check("ready_after_release", bus.pkt_ready, 1);
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: the packet is chunked into slices of WPS words; only the
  // first MAXS slices are forwarded, each beat one cycle after its final word.
  task automatic send_pkt(input int n, input int gap_before, input int gap_len,
                          input int abort_after, input bit use_first,
                          input logic [PW-1:0] first);
    logic [PW-1:0] w[$];
    exp_t          e;
    layer_info_t   ctx;
    bit            ok;
    int            s;
    for (int i = 0; i < n; i++) begin
      w.push_back({$urandom, $urandom, $urandom, $urandom});
    end
    if (use_first) w[0] = first;
    ctx = '0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_after) begin
        do_reset();
        return;
      end
      if (i > 0 && i == gap_before) begin
        repeat (gap_len) @(posedge i_clk);
        #1;
      end
      put_word(w[i], (i == n - 1), ok);
      if (i == 0) begin
        ctx.type_offset  = init_to;
        ctx.key_offset_v = init_kv;
        ctx.key_offset   = init_ko;
        ctx.headShift    = init_hs;
      end
      s = i / WPS;
      if (s < MAXS && ((i % WPS) == WPS - 1 || i == n - 1)) begin
        e.li           = ctx;
        e.li.tag_valid = 1'b1;
        e.li.tag_start = (s == 0);
        e.li.tag_last  = (i == n - 1) || (s == MAXS - 1);
        for (int k = 0; k <= i - s * WPS; k++) begin
          e.li.head[HEAD_WIDTH-1-k*PW -: PW] = w[s*WPS+k];
        end
        e.cyc = acc_cyc + 1;
        sb.push_back(e);
      end
      if (i >= MAXS * WPS) m_drop++;
    end
    m_pkt++;
    @(negedge i_clk);
    check("pkt_cnt", pkt_cnt, m_pkt);
    check("drop_word_cnt", drop_cnt, m_drop);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] aabb;
    aabb = {8{16'hAABB}};
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    bus.pkt_last  = 1'b0;
    drive_init_random();
    #2;
    do_reset();

    send_pkt(1,  -1, 0, -1, 1'b1, aabb);   // single-word packet
    send_pkt(8,  -1, 0, -1, 1'b0, '0);     // exactly two slices
    send_pkt(11, -1, 0, -1, 1'b0, '0);     // two slices + 3 dropped words
    send_pkt(6,   2, 2, -1, 1'b0, '0);     // idle gap mid-slice
    send_pkt(4,  -1, 0,  2, 1'b0, '0);     // reset after word 2
    send_pkt(1,  -1, 0, -1, 1'b0, '0);     // recovery after reset

    for (int p = 0; p < 30; p++) begin
      send_pkt($urandom_range(1, 13), $urandom_range(1, 12), $urandom_range(0, 3),
               -1, 1'b0, '0);
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
      #1;
    end

    repeat (4) @(negedge i_clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
